imem_loader: RTL and testbench

Boot-time instruction memory writer for the single-cycle ARM core. It accepts a little-endian byte stream from a host link over a valid/ready handshake and assembles 32-bit instruction words. It writes those words sequentially into instruction memory from word address 0, holding the core in reset until the load completes. It is the producing end of the instruction path whose words the core's decoder later fetches and decodes.

---
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader.sv | 61 ++++++
 tb/tb_imem_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte stream, start/count control and imem write bus for the boot loader
interface imem_loader_if #(parameter int ADDR_WIDTH = 6) ();
  logic                  start;
  logic [ADDR_WIDTH:0]   word_count;
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wd;
  logic                  cpu_reset;
  logic                  busy;
  logic                  done;
  logic [31:0]           checksum;
  modport master (
    output start, word_count, in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wd, cpu_reset, busy, done, checksum
  );
  modport slave (
    input  start, word_count, in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wd, cpu_reset, busy, done, checksum
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles little-endian host bytes into 32-bit words and writes them to imem from address 0
module imem_loader #(parameter int ADDR_WIDTH = 6) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RECV, WRITE, RUN} state_t;
  localparam logic [ADDR_WIDTH:0] cap = {1'b1, {ADDR_WIDTH{1'b0}}};
  state_t                state, state_n;
  logic [ADDR_WIDTH:0]   count, clamp;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            byte_idx;
  logic [31:0]           asm_word, sum;
  logic                  last, take;
  assign clamp = bus.word_count > cap ? cap : bus.word_count;
  assign last  = {1'b0, word_idx} == count - (ADDR_WIDTH+1)'(1);
  assign take  = state == RECV && bus.in_valid;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.start ? (clamp == '0 ? RUN : RECV) : IDLE;
      RECV:    state_n = take && byte_idx == 2'd3 ? WRITE : RECV;
      WRITE:   state_n = last ? RUN : RECV;
      default: state_n = RUN;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      asm_word <= '0;
      sum      <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.start) begin
        count    <= clamp;
        word_idx <= '0;
        byte_idx <= '0;
        sum      <= '0;
      end
      if (take) begin
        asm_word[{byte_idx, 3'b000} +: 8] <= bus.in_data;
        byte_idx <= byte_idx + 2'd1;
      end
      // the last word leaves word_idx at the top address instead of wrapping
      if (state == WRITE) begin
        sum <= sum + asm_word;
        if (!last) word_idx <= word_idx + ADDR_WIDTH'(1);
      end
    end
  assign bus.in_ready  = state == RECV;
  assign bus.imem_we   = state == WRITE;
  assign bus.imem_addr = state == WRITE ? word_idx : '0;
  assign bus.imem_wd   = state == WRITE ? asm_word : '0;
  assign bus.cpu_reset = state != RUN;
  assign bus.busy      = state == RECV || state == WRITE;
  assign bus.done      = state == RUN;
  assign bus.checksum  = sum;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed loads checked against a write-queue/checksum model and a behavioural memory
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  imem_loader_if #(.ADDR_WIDTH(6)) bus ();
  imem_loader #(.ADDR_WIDTH(6)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  typedef struct packed {logic [5:0] a; logic [31:0] d;} wr_t;
  wr_t         exp_q[$];
  wr_t         e;
  logic [31:0] mem [64];
  logic [31:0] full [64];
  logic [31:0] model_sum = '0;
  logic [5:0]  next_addr = '0;
  int          nvec = 0;
  int          nerr = 0;
  bit          armed = 1'b0;
  time         t0, td;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  always @(posedge clk) if (bus.imem_we) mem[bus.imem_addr] <= bus.imem_wd;
  always @(negedge clk)
    if (armed && !reset) begin
      if (bus.busy || bus.done) chk("checksum", bus.checksum, model_sum);
      chk("cpu_reset_vs_done", {31'b0, bus.cpu_reset}, {31'b0, !bus.done});
      if (bus.imem_we) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL spurious_write: got addr %0d data %h want no write", bus.imem_addr, bus.imem_wd);
        end else begin
          e = exp_q.pop_front();
          chk("imem_addr", {26'b0, bus.imem_addr}, {26'b0, e.a});
          chk("imem_wd", bus.imem_wd, e.d);
          model_sum = model_sum + e.d;
        end
      end
    end
  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_imem_we", bus.imem_we, 0);
    chk("rst_imem_addr", bus.imem_addr, 0);
    chk("rst_imem_wd", bus.imem_wd, 0);
    chk("rst_cpu_reset", bus.cpu_reset, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_checksum", bus.checksum, 0);
    exp_q.delete();
    model_sum = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask
  task automatic start_load(input logic [6:0] wc, output time ts);
    bus.word_count = wc;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    ts = $time;
    next_addr = '0;
    model_sum = '0;
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit rdy = 1'b0;
    int n = 0;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.in_data = b;
    bus.in_valid = 1'b1;
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy) begin
      nvec++;
      nerr++;
      $display("FAIL byte_accept: got no in_ready in %0d cycles want acceptance", n);
    end
  endtask
  task automatic send_word(input logic [31:0] w, input int gap);
    exp_q.push_back({next_addr, w});
    next_addr++;
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], (k % 2 == 1) ? gap : 0);
  endtask
  task automatic wait_done(output time tend);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 400);
    tend = $time;
    chk("done_reached", bus.done, 1);
    chk("pending_writes", exp_q.size(), 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.word_count = '0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    do_reset();
    armed = 1'b1;
    start_load(7'd1, t0);
    chk("in_ready_after_start", bus.in_ready, 1);
    send_word(32'hE28F0004, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("single_we", bus.imem_we, 1);
    chk("single_addr", bus.imem_addr, 0);
    chk("single_wd", bus.imem_wd, 32'hE28F0004);
    chk("single_done_in_write", bus.done, 0);
    @(negedge clk);
    chk("single_done", bus.done, 1);
    chk("single_cpu_reset", bus.cpu_reset, 0);
    chk("single_checksum", bus.checksum, 32'hE28F0004);
    chk("single_busy", bus.busy, 0);
    chk("single_latency", 32'((($time - t0) - 4) / 10), 5);
    chk("single_mem0", mem[0], 32'hE28F0004);
    chk("single_pending", exp_q.size(), 0);
    do_reset();
    start_load(7'd2, t0);
    send_word(32'hFFFFFFFF, 2);
    send_word(32'h00000002, 2);
    bus.in_valid = 1'b0;
    wait_done(td);
    chk("bp_checksum", bus.checksum, 32'h00000001);
    chk("bp_mem0", mem[0], 32'hFFFFFFFF);
    chk("bp_mem1", mem[1], 32'h00000002);
    bus.word_count = 7'd3;
    bus.start = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk("run_start_done", bus.done, 1);
    chk("run_start_busy", bus.busy, 0);
    chk("run_start_checksum", bus.checksum, 32'h00000001);
    do_reset();
    start_load(7'd0, t0);
    @(negedge clk);
    chk("zero_done", bus.done, 1);
    chk("zero_busy", bus.busy, 0);
    chk("zero_in_ready", bus.in_ready, 0);
    chk("zero_checksum", bus.checksum, 0);
    repeat (3) @(negedge clk);
    do_reset();
    for (int i = 0; i < 64; i++) full[i] = 32'h9E3779B9 * i + 32'h01000001;
    start_load(7'd65, t0);
    for (int i = 0; i < 64; i++) send_word(full[i], 0);
    bus.in_valid = 1'b0;
    wait_done(td);
    chk("full_latency", 32'(((td - t0) - 4) / 10), 320);
    for (int i = 0; i < 64; i++) chk($sformatf("full_mem%0d", i), mem[i], full[i]);
    bus.in_data = 8'h55;
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("run_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    do_reset();
    start_load(7'd5, t0);
    send_word(32'hA1A2A3A4, 0);
    bus.in_valid = 1'b0;
    bus.word_count = 7'd1;
    bus.start = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    chk("recv_start_busy", bus.busy, 1);
    send_word(32'hB1B2B3B4, 0);
    send_word(32'hC1C2C3C4, 2);
    send_byte(8'hD4, 0);
    send_byte(8'hD3, 1);
    bus.in_valid = 1'b0;
    do_reset();
    chk("mid_mem0", mem[0], 32'hA1A2A3A4);
    chk("mid_mem1", mem[1], 32'hB1B2B3B4);
    chk("mid_mem2", mem[2], 32'hC1C2C3C4);
    chk("mid_mem3_kept", mem[3], full[3]);
    bus.in_data = 8'hD2;
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", bus.busy, 0);
      chk("idle_in_ready", bus.in_ready, 0);
      chk("idle_done", bus.done, 0);
      chk("idle_cpu_reset", bus.cpu_reset, 1);
    end
    bus.in_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
